// File: rtl/line_clear.sv
// Line-clear and game-over engine: scans the playfield bottom-up after each
// lock, drops full rows, compacts the rest downward and zero-fills the top.
module line_clear #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int AW     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    row_addr,
    input  logic [WIDTH-1:0] row_rdata,
    output logic [WIDTH-1:0] row_wdata,
    output logic             row_we,
    output logic             busy,
    output logic             done,
    output logic             aligne,
    output logic             perdu,
    output logic [AW-1:0]    lines
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EVAL = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [AW-1:0]        LAST   = AW'(HEIGHT - 1);
    localparam logic [AW-1:0]        HMAX   = AW'(HEIGHT);
    localparam logic signed [AW:0]   W_LAST = (AW+1)'(HEIGHT - 1);
    localparam logic signed [AW:0]   W_ONE  = (AW+1)'(1);

    logic [2:0]            state;
    logic [AW-1:0]         r;
    logic signed [AW:0]    w;
    logic [AW-1:0]         cnt;
    logic [AW-1:0]         cnt_n;
    logic                  top_nz;
    logic                  full;
    logic                  r_eq_w;

    assign full   = &row_rdata;
    assign r_eq_w = (w == {1'b0, r});
    assign busy   = (state != S_IDLE);

    // cnt saturates at HEIGHT, which only an all-full grid can reach
    always_comb begin
        cnt_n = cnt;
        if (full && (cnt != HMAX)) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_comb begin
        row_addr  = '0;
        row_wdata = '0;
        row_we    = 1'b0;
        aligne    = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_RD: begin
                row_addr = r;
            end
            S_EVAL: begin
                row_addr = w[AW-1:0];
                if (full) begin
                    aligne = 1'b1;
                end else if (!r_eq_w) begin
                    row_we    = 1'b1;
                    row_wdata = row_rdata;
                end
            end
            S_FILL: begin
                row_we   = 1'b1;
                row_addr = w[AW-1:0];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            r      <= '0;
            w      <= '0;
            cnt    <= '0;
            top_nz <= 1'b0;
            perdu  <= 1'b0;
            lines  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !perdu) begin
                        r      <= LAST;
                        w      <= W_LAST;
                        cnt    <= '0;
                        top_nz <= 1'b0;
                        state  <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    cnt <= cnt_n;
                    if (!full) begin
                        w <= w - W_ONE;
                    end
                    if (r == '0) begin
                        top_nz <= (row_rdata != '0) && !full;
                        if (cnt_n != '0) begin
                            state <= S_FILL;
                        end else begin
                            state <= S_DONE;
                            lines <= cnt_n;
                        end
                    end else begin
                        r     <= r - 1'b1;
                        state <= S_RD;
                    end
                end
                S_FILL: begin
                    w <= w - W_ONE;
                    if (w == '0) begin
                        state <= S_DONE;
                        lines <= cnt;
                    end
                end
                S_DONE: begin
                    // a cleared row always empties row 0, so only cnt=0 can lose
                    if ((cnt == '0) && top_nz) begin
                        perdu <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Directed testbench for line_clear with a behavioural 1-cycle-read grid.
module tb_line_clear;

    localparam int WIDTH  = 10;
    localparam int HEIGHT = 20;
    localparam int AW     = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    row_addr;
    logic [WIDTH-1:0] row_rdata;
    logic [WIDTH-1:0] row_wdata;
    logic             row_we;
    logic             busy;
    logic             done;
    logic             aligne;
    logic             perdu;
    logic [AW-1:0]    lines;

    line_clear #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .row_addr(row_addr),
        .row_rdata(row_rdata),
        .row_wdata(row_wdata),
        .row_we(row_we),
        .busy(busy),
        .done(done),
        .aligne(aligne),
        .perdu(perdu),
        .lines(lines)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [HEIGHT];
    logic [WIDTH-1:0] img [HEIGHT];
    logic [WIDTH-1:0] exp_g [HEIGHT];
    logic             ld = 1'b0;
    int               cyc = 0;

    always @(posedge clk) begin
        if (ld) mem <= img;
        else if (row_we) mem[row_addr] <= row_wdata;
        row_rdata <= mem[row_addr];
        cyc <= cyc + 1;
    end

    int checks = 0;
    int failures = 0;

    int s_cyc, lat, n_al, n_wr, min_gap, last_al;
    logic busy1;
    logic [AW-1:0] lines_d;

    task automatic clear_img();
        for (int i = 0; i < HEIGHT; i++) begin
            img[i] = '0;
            exp_g[i] = '0;
        end
    endtask

    task automatic load_grid();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic run_scan(input int extra_at);
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        n_al = 0; n_wr = 0; lat = -1;
        min_gap = 1000; last_al = -1000;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            start = (i == extra_at);
            if (aligne) begin
                if (cyc - last_al < min_gap) min_gap = cyc - last_al;
                last_al = cyc;
                n_al++;
            end
            if (row_we) n_wr++;
            if (done) begin
                lat = cyc - s_cyc;
                lines_d = lines;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, aligne, perdu, row_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, aligne, perdu, row_we});
        end
        checks++;
        if (row_addr !== '0 || row_wdata !== '0 || lines !== '0) begin
            failures++;
            $display("FAIL reset_buses: addr=%0d wdata=%h lines=%0d want 0",
                     row_addr, row_wdata, lines);
        end
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_with_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic check_grid(input string name);
        for (int i = 0; i < HEIGHT; i++) begin
            checks++;
            if (mem[i] !== exp_g[i]) begin
                failures++;
                $display("FAIL %s row%0d: got %h want %h",
                         name, i, mem[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_empty();
        clear_img();
        load_grid();
        run_scan(-1);
        checks++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL empty_busy: got %b want 1", busy1);
        end
        checks++;
        if (lat != 41) begin
            failures++;
            $display("FAIL empty_lat: got %0d want 41", lat);
        end
        checks++;
        if (n_al != 0 || n_wr != 0) begin
            failures++;
            $display("FAIL empty_act: aligne=%0d writes=%0d want 0 0",
                     n_al, n_wr);
        end
        checks++;
        if (lines_d !== 5'd0) begin
            failures++;
            $display("FAIL empty_lines: got %0d want 0", lines_d);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || perdu !== 1'b0) begin
            failures++;
            $display("FAIL empty_after: busy=%b perdu=%b want 0 0",
                     busy, perdu);
        end
    endtask

    task automatic test_single();
        clear_img();
        img[19] = 10'h3FF;
        img[18] = 10'h001;
        exp_g[19] = 10'h001;
        load_grid();
        run_scan(-1);
        checks++;
        if (lat != 42) begin
            failures++;
            $display("FAIL single_lat: got %0d want 42", lat);
        end
        checks++;
        if (n_al != 1 || n_wr != 20) begin
            failures++;
            $display("FAIL single_act: aligne=%0d writes=%0d want 1 20",
                     n_al, n_wr);
        end
        checks++;
        if (lines_d !== 5'd1) begin
            failures++;
            $display("FAIL single_lines: got %0d want 1", lines_d);
        end
        @(negedge clk);
        check_grid("single");
    endtask

    task automatic test_quad();
        clear_img();
        for (int i = 16; i < 20; i++) img[i] = 10'h3FF;
        img[15] = 10'h2A5;
        exp_g[19] = 10'h2A5;
        load_grid();
        run_scan(-1);
        checks++;
        if (n_al != 4 || min_gap != 2) begin
            failures++;
            $display("FAIL quad_aligne: count=%0d gap=%0d want 4 2",
                     n_al, min_gap);
        end
        checks++;
        if (lat != 45 || lines_d !== 5'd4) begin
            failures++;
            $display("FAIL quad_done: lat=%0d lines=%0d want 45 4",
                     lat, lines_d);
        end
        @(negedge clk);
        checks++;
        if (lines !== 5'd4) begin
            failures++;
            $display("FAIL quad_lines_held: got %0d want 4", lines);
        end
        check_grid("quad");
    endtask

    task automatic test_gameover();
        logic stuck;
        clear_img();
        img[0] = 10'h010;
        load_grid();
        run_scan(-1);
        checks++;
        if (lat != 41 || n_al != 0 || n_wr != 0 || perdu !== 1'b0) begin
            failures++;
            $display("FAIL over_scan: lat=%0d al=%0d wr=%0d perdu=%b want 41 0 0 0",
                     lat, n_al, n_wr, perdu);
        end
        @(negedge clk);
        checks++;
        if (perdu !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL over_perdu: perdu=%b busy=%b want 1 0", perdu, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stuck = 1'b0;
        repeat (4) begin
            if (busy !== 1'b0) stuck = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stuck !== 1'b0 || perdu !== 1'b1) begin
            failures++;
            $display("FAIL over_ignore: busy_seen=%b perdu=%b want 0 1",
                     stuck, perdu);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (perdu !== 1'b0) begin
            failures++;
            $display("FAIL over_reset: perdu=%b want 0", perdu);
        end
    endtask

    task automatic test_over_clear();
        clear_img();
        img[0] = 10'h010;
        img[19] = 10'h3FF;
        exp_g[1] = 10'h010;
        load_grid();
        run_scan(-1);
        checks++;
        if (lat != 42 || n_al != 1 || lines_d !== 5'd1) begin
            failures++;
            $display("FAIL clr_scan: lat=%0d al=%0d lines=%0d want 42 1 1",
                     lat, n_al, lines_d);
        end
        @(negedge clk);
        checks++;
        if (perdu !== 1'b0) begin
            failures++;
            $display("FAIL clr_perdu: got %b want 0", perdu);
        end
        check_grid("clr");
    endtask

    task automatic test_back_to_back();
        clear_img();
        load_grid();
        run_scan(10);
        checks++;
        if (lat != 41 || n_wr != 0) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d writes=%0d want 41 0", lat, n_wr);
        end
        run_scan(-1);
        checks++;
        if (lat != 41 || lines_d !== 5'd0) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d lines=%0d want 41 0", lat, lines_d);
        end
    endtask

    task automatic test_abort();
        clear_img();
        img[19] = 10'h3FF;
        load_grid();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_pre: got %b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, row_we, done, aligne, perdu} !== 5'b0 ||
            row_addr !== '0 || row_wdata !== '0 || lines !== '0) begin
            failures++;
            $display("FAIL abort_outs: flags=%b addr=%0d wdata=%h lines=%0d want 0",
                     {busy, row_we, done, aligne, perdu}, row_addr, row_wdata, lines);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_empty();
        test_single();
        test_quad();
        test_gameover();
        test_over_clear();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
